// File: rtl/tcu_pkg.sv
// Shared types and helpers for the TCU sample scheduler: FSM state encoding,
// datapath widths and the P3T raw-register decode.
package tcu_pkg;

  localparam int TEMP_W = 12;
  localparam int RAW_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE,
    S_RETRY,
    S_PUBLISH,
    S_WAIT_PERIOD,
    S_FAULT
  } sched_state_t;

  // The sensor left-justifies its 12-bit two's-complement reading.
  function automatic logic signed [TEMP_W-1:0] raw_to_temp(input logic [RAW_W-1:0] raw);
    return TEMP_W'(raw >> (RAW_W - TEMP_W));
  endfunction

endpackage

// File: rtl/tcu_timer.sv
// Loadable down-counter; expire pulses for one cycle in the cycle the count
// reaches zero, after which the count rests at zero until reloaded.
module tcu_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count_q, count_d;
  logic         expire_q, expire_d;

  always_comb begin
    count_d  = count_q;
    expire_d = 1'b0;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d  = count_q - 1'b1;
      expire_d = (count_q == W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      expire_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      expire_q <= expire_d;
    end
  end

  assign expire = expire_q;

endmodule

// File: rtl/tcu_sample_scheduler.sv
// Periodic temperature read sequencer with timeout/retry, hysteretic alarm and
// sticky sensor fault. Define TCU_SCHED_AVG_EN to publish a 4-sample mean.
module tcu_sample_scheduler
  import tcu_pkg::*;
#(
  parameter int unsigned              PERIOD_CYCLES  = 1_500_000,
  parameter int unsigned              TIMEOUT_CYCLES = 20_000,
  parameter int unsigned              MAX_RETRIES    = 3,
  parameter logic signed [TEMP_W-1:0] T_HIGH         = 12'sd1200,
  parameter logic signed [TEMP_W-1:0] T_LOW          = 12'sd1120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear_fault,
  output logic              i2c_start,
  input  logic              i2c_busy,
  input  logic              i2c_done,
  input  logic              i2c_ack_err,
  input  logic [RAW_W-1:0]  i2c_data,
  output logic [TEMP_W-1:0] temp_out,
  output logic              temp_valid,
  output logic              over_temp,
  output logic              sensor_fault
);

  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  // Loads absorb the FSM hops between expiry and the next start pulse, so
  // start-to-start is PERIOD_CYCLES (no retry) or TIMEOUT_CYCLES (on timeout).
  localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYCLES - 2);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYCLES - 3);

  sched_state_t             state_q, state_d;
  logic [RET_W-1:0]         retry_q, retry_d;
  logic                     i2c_start_q, i2c_start_d;
  logic signed [TEMP_W-1:0] temp_out_q, temp_out_d;
  logic                     temp_valid_q, temp_valid_d;
  logic                     over_temp_q, over_temp_d;
  logic                     sensor_fault_q, sensor_fault_d;
  logic                     period_due_q, period_due_d;

  logic                     issue_fire, period_load;
  logic                     period_expire, timeout_expire;
  logic                     publish_fire, clear_fire;
  logic signed [TEMP_W-1:0] sample_temp, pub_temp;

  assign sample_temp  = raw_to_temp(i2c_data);
  assign issue_fire   = (state_q == S_ISSUE) && enable && !i2c_busy;
  assign period_load  = issue_fire && (retry_q == '0);
  assign publish_fire = (state_q == S_WAIT_DONE) && i2c_done && !i2c_ack_err;
  assign clear_fire   = (state_q == S_FAULT) && clear_fault;

  tcu_timer #(.W(PER_W)) u_period (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (period_load),
    .load_val (PER_LOAD),
    .expire   (period_expire)
  );

  tcu_timer #(.W(TO_W)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (issue_fire),
    .load_val (TO_LOAD),
    .expire   (timeout_expire)
  );

  // Remembers a period that elapsed while retries were still running.
  assign period_due_d = period_load ? 1'b0 : (period_due_q | period_expire);

`ifdef TCU_SCHED_AVG_EN
  logic signed [TEMP_W-1:0] hist_q [3];
  logic signed [TEMP_W-1:0] hist_d [3];
  logic                     fill_q, fill_d;
  logic signed [TEMP_W+1:0] avg_sum;

  always_comb begin
    if (fill_q) begin
      avg_sum = (TEMP_W+2)'(sample_temp) <<< 2;
    end else begin
      avg_sum = (TEMP_W+2)'(sample_temp) + (TEMP_W+2)'(hist_q[0])
              + (TEMP_W+2)'(hist_q[1]) + (TEMP_W+2)'(hist_q[2]);
    end
  end

  assign pub_temp = TEMP_W'(avg_sum >>> 2);
  assign fill_d   = clear_fire ? 1'b1 : (publish_fire ? 1'b0 : fill_q);

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_hist
      if (gi == 0) begin : g_head
        assign hist_d[gi] = publish_fire ? sample_temp : hist_q[gi];
      end else begin : g_tail
        assign hist_d[gi] = publish_fire ? (fill_q ? sample_temp : hist_q[gi-1]) : hist_q[gi];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist_q[gi] <= '0;
        else        hist_q[gi] <= hist_d[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fill_q <= 1'b1;
    else        fill_q <= fill_d;
  end
`else
  assign pub_temp = sample_temp;
`endif

  always_comb begin
    state_d        = state_q;
    retry_d        = retry_q;
    i2c_start_d    = 1'b0;
    temp_out_d     = temp_out_q;
    temp_valid_d   = 1'b0;
    over_temp_d    = over_temp_q;
    sensor_fault_d = sensor_fault_q;
    case (state_q)
      S_IDLE: if (enable) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!enable) begin
          state_d = S_IDLE;
          retry_d = '0;
        end else if (!i2c_busy) begin
          i2c_start_d = 1'b1;
          state_d     = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        // Result goes out the cycle after done; PUBLISH only retires it.
        if (publish_fire) begin
          temp_out_d   = pub_temp;
          temp_valid_d = 1'b1;
          if (pub_temp >= T_HIGH)    over_temp_d = 1'b1;
          else if (pub_temp < T_LOW) over_temp_d = 1'b0;
          state_d = S_PUBLISH;
        end else if (i2c_done || timeout_expire) begin
          if (enable) begin
            state_d = S_RETRY;
          end else begin
            state_d = S_IDLE;
            retry_d = '0;
          end
        end
      end
      S_RETRY: begin
        if (retry_q < RET_W'(MAX_RETRIES)) begin
          retry_d = retry_q + 1'b1;
          state_d = S_ISSUE;
        end else begin
          sensor_fault_d = 1'b1;
          state_d        = S_FAULT;
        end
      end
      S_PUBLISH: begin
        retry_d = '0;
        state_d = enable ? S_WAIT_PERIOD : S_IDLE;
      end
      S_WAIT_PERIOD: begin
        if (!enable)                             state_d = S_IDLE;
        else if (period_due_q || period_expire)  state_d = S_ISSUE;
      end
      S_FAULT: begin
        if (clear_fire) begin
          sensor_fault_d = 1'b0;
          retry_d        = '0;
          state_d        = enable ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      retry_q        <= '0;
      i2c_start_q    <= 1'b0;
      temp_out_q     <= '0;
      temp_valid_q   <= 1'b0;
      over_temp_q    <= 1'b0;
      sensor_fault_q <= 1'b0;
      period_due_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      retry_q        <= retry_d;
      i2c_start_q    <= i2c_start_d;
      temp_out_q     <= temp_out_d;
      temp_valid_q   <= temp_valid_d;
      over_temp_q    <= over_temp_d;
      sensor_fault_q <= sensor_fault_d;
      period_due_q   <= period_due_d;
    end
  end

  assign i2c_start    = i2c_start_q;
  assign temp_out     = temp_out_q;
  assign temp_valid   = temp_valid_q;
  assign over_temp    = over_temp_q;
  assign sensor_fault = sensor_fault_q;

endmodule

// File: tb/tb_tcu_sample_scheduler.sv
// Scoreboard bench for tcu_sample_scheduler with a behavioural I2C engine.
// Honours TCU_SCHED_AVG_EN to switch between raw and averaged expectations.
module tb_tcu_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        clear_fault = 1'b0;
  logic        i2c_start;
  logic        i2c_busy = 1'b0;
  logic        i2c_done = 1'b0;
  logic        i2c_ack_err = 1'b0;
  logic [15:0] i2c_data = 16'h0000;
  logic [11:0] temp_out;
  logic        temp_valid;
  logic        over_temp;
  logic        sensor_fault;

  tcu_sample_scheduler #(
    .PERIOD_CYCLES  (100),
    .TIMEOUT_CYCLES (50),
    .MAX_RETRIES    (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .clear_fault  (clear_fault),
    .i2c_start    (i2c_start),
    .i2c_busy     (i2c_busy),
    .i2c_done     (i2c_done),
    .i2c_ack_err  (i2c_ack_err),
    .i2c_data     (i2c_data),
    .temp_out     (temp_out),
    .temp_valid   (temp_valid),
    .over_temp    (over_temp),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          respond;
    int          delay;
    bit          ack;
    logic [15:0] data;
  } resp_t;

  typedef struct {
    logic [11:0] temp;
    logic        ot;
  } exp_t;

  resp_t       resp_q[$];
  exp_t        exp_q[$];
  int          start_t[$];
  int          avg_hist[$];
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          n_start = 0;
  int          n_valid = 0;
  int          eng_cnt = 0;
  bit          eng_ack = 1'b0;
  logic [15:0] eng_data = 16'h0000;
  bit          model_ot = 1'b0;
  bit          avg_fill = 1'b1;

  always @(posedge clk) cyc++;

  // Expected result of a successful read, pushed when the engine answers.
  function automatic void push_expected(input logic [15:0] raw);
    logic signed [11:0] s;
    int   t;
    int   sum;
    exp_t e;
    s = raw[15:4];
    t = s;
`ifdef TCU_SCHED_AVG_EN
    if (avg_fill) begin
      avg_hist.delete();
      for (int k = 0; k < 4; k++) avg_hist.push_back(t);
      avg_fill = 1'b0;
    end else begin
      avg_hist.push_back(t);
      void'(avg_hist.pop_front());
    end
    sum = 0;
    foreach (avg_hist[k]) sum += avg_hist[k];
    t = sum >>> 2;
`else
    sum = t;
`endif
    if (t >= 1200)     model_ot = 1'b1;
    else if (t < 1120) model_ot = 1'b0;
    e.temp = t[11:0];
    e.ot   = model_ot;
    exp_q.push_back(e);
  endfunction

  // I2C engine model: answers each start pulse from the response queue.
  always @(negedge clk) begin : engine
    resp_t r;
    if (!rst_n) begin
      eng_cnt     = 0;
      i2c_busy    = 1'b0;
      i2c_done    = 1'b0;
      i2c_ack_err = 1'b0;
    end else begin
      i2c_done    = 1'b0;
      i2c_ack_err = 1'b0;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          i2c_done    = 1'b1;
          i2c_ack_err = eng_ack;
          i2c_data    = eng_data;
          i2c_busy    = 1'b0;
          if (!eng_ack) push_expected(eng_data);
        end
      end
      if (i2c_start === 1'b1 && resp_q.size() > 0) begin
        r = resp_q.pop_front();
        if (r.respond) begin
          eng_cnt  = r.delay;
          eng_ack  = r.ack;
          eng_data = r.data;
          i2c_busy = 1'b1;
        end
      end
    end
  end

  // Monitor: counts starts and checks every published sample.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (i2c_start === 1'b1) begin
        n_start++;
        start_t.push_back(cyc);
      end
      if (temp_valid === 1'b1) begin
        n_valid++;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL unexpected_valid: temp_out=%h over_temp=%b, no sample was pending", temp_out, over_temp);
        end else begin
          e = exp_q.pop_front();
          if (temp_out !== e.temp || over_temp !== e.ot) begin
            tests_failed++;
            $display("FAIL sample: got temp_out=%h over_temp=%b, want temp_out=%h over_temp=%b",
                     temp_out, over_temp, e.temp, e.ot);
          end else begin
            $display("[TB] cyc %0d sample temp_out=%h over_temp=%b", cyc, temp_out, over_temp);
          end
        end
      end
    end
  end

  task automatic clear_counts();
    n_start = 0;
    n_valid = 0;
    start_t.delete();
  endtask

  task automatic push_resp(input bit respond, input int delay, input bit ack, input logic [15:0] data);
    resp_t r;
    r.respond = respond;
    r.delay   = delay;
    r.ack     = ack;
    r.data    = data;
    resp_q.push_back(r);
  endtask

  task automatic check_outputs_zero(input string tag);
    tests_run++;
    if ({i2c_start, temp_out, temp_valid, over_temp, sensor_fault} !== 16'h0000) begin
      tests_failed++;
      $display("FAIL %s: got start=%b temp_out=%h valid=%b ot=%b fault=%b, want all 0",
               tag, i2c_start, temp_out, temp_valid, over_temp, sensor_fault);
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset_state");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    tests_run++;
    if (i2c_start !== 1'b0 || n_start != 0) begin
      tests_failed++;
      $display("FAIL idle_no_start: got starts=%0d, want 0", n_start);
    end
  endtask

  task automatic test_basic();
    clear_counts();
    push_resp(1, 20, 0, 16'h1900);
    push_resp(1, 20, 0, 16'h1900);
    enable = 1'b1;
    for (int i = 0; i < 400 && n_start < 2; i++) @(negedge clk);
    tests_run++;
    if (n_start != 2) begin
      tests_failed++;
      $display("FAIL basic_starts: got %0d starts, want 2", n_start);
    end else begin
      tests_run++;
      if (start_t[1] - start_t[0] != 100) begin
        tests_failed++;
        $display("FAIL basic_period: got spacing %0d, want 100", start_t[1] - start_t[0]);
      end
    end
    tests_run++;
    if (n_valid != 1) begin
      tests_failed++;
      $display("FAIL basic_one_valid: got %0d valids, want 1", n_valid);
    end
    enable = 1'b0;
    repeat (60) @(negedge clk);
    tests_run++;
    if (temp_out !== 12'h190 || n_valid != 2) begin
      tests_failed++;
      $display("FAIL basic_temp: got temp_out=%h valids=%0d, want 190 and 2", temp_out, n_valid);
    end
  endtask

  task automatic test_retry();
    clear_counts();
    push_resp(1, 20, 1, 16'h0000);
    push_resp(1, 20, 1, 16'h0000);
    push_resp(1, 20, 0, 16'h1900);
    enable = 1'b1;
    for (int i = 0; i < 400 && n_valid < 1; i++) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (n_start != 3 || n_valid != 1 || sensor_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL retry: got starts=%0d valids=%0d fault=%b, want 3 1 0", n_start, n_valid, sensor_fault);
    end
  endtask

  task automatic test_timeout();
    int tclr;
    clear_counts();
    for (int k = 0; k < 3; k++) push_resp(0, 0, 0, 16'h0000);
    enable = 1'b1;
    for (int i = 0; i < 400 && sensor_fault !== 1'b1; i++) @(negedge clk);
    tests_run++;
    if (sensor_fault !== 1'b1 || n_start != 3) begin
      tests_failed++;
      $display("FAIL timeout_fault: got fault=%b starts=%0d, want 1 and 3", sensor_fault, n_start);
    end else begin
      tests_run++;
      if (start_t[1] - start_t[0] != 50 || start_t[2] - start_t[1] != 50) begin
        tests_failed++;
        $display("FAIL timeout_spacing: got %0d %0d, want 50 50",
                 start_t[1] - start_t[0], start_t[2] - start_t[1]);
      end
    end
    repeat (200) @(negedge clk);
    tests_run++;
    if (n_start != 3 || sensor_fault !== 1'b1) begin
      tests_failed++;
      $display("FAIL fault_quiet: got starts=%0d fault=%b, want 3 and 1", n_start, sensor_fault);
    end
    push_resp(1, 20, 0, 16'h1900);
    clear_fault = 1'b1;
    avg_fill    = 1'b1;
    tclr        = cyc;
    @(negedge clk);
    clear_fault = 1'b0;
    for (int i = 0; i < 10 && n_start < 4; i++) @(negedge clk);
    tests_run++;
    if (n_start != 4) begin
      tests_failed++;
      $display("FAIL clear_restart: got %0d starts, want 4", n_start);
    end else if (start_t[3] - tclr > 2) begin
      tests_failed++;
      $display("FAIL clear_restart: got start %0d cycles after clear, want <= 2", start_t[3] - tclr);
    end
    tests_run++;
    if (sensor_fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_fault: got sensor_fault=%b, want 0", sensor_fault);
    end
    for (int i = 0; i < 60 && n_valid < 1; i++) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (n_valid != 1) begin
      tests_failed++;
      $display("FAIL clear_sample: got %0d valids, want 1", n_valid);
    end
  endtask

`ifdef TCU_SCHED_AVG_EN
  task automatic test_average();
    clear_counts();
    push_resp(1, 20, 0, 16'h1900);
    push_resp(1, 20, 0, 16'h1900);
    push_resp(1, 20, 0, 16'h1900);
    push_resp(1, 20, 0, 16'h1940);
    enable = 1'b1;
    for (int i = 0; i < 600 && n_valid < 4; i++) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (n_valid != 4 || temp_out !== 12'd401) begin
      tests_failed++;
      $display("FAIL average: got valids=%0d temp_out=%0d, want 4 and 401", n_valid, temp_out);
    end
  endtask
`else
  task automatic test_over_temp();
    clear_counts();
    push_resp(1, 20, 0, 16'h4B00);
    push_resp(1, 20, 0, 16'h4600);
    push_resp(1, 20, 0, 16'h45F0);
    push_resp(1, 20, 0, 16'hFF00);
    enable = 1'b1;
    for (int i = 0; i < 600 && n_valid < 4; i++) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (n_valid != 4 || temp_out !== 12'hFF0 || over_temp !== 1'b0) begin
      tests_failed++;
      $display("FAIL over_temp_final: got valids=%0d temp_out=%h ot=%b, want 4 FF0 0",
               n_valid, temp_out, over_temp);
    end
  endtask
`endif

  task automatic test_reset_mid();
    clear_counts();
    push_resp(1, 30, 0, 16'h4B00);
    enable = 1'b1;
    for (int i = 0; i < 300 && n_start < 1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_outputs_zero("reset_mid");
    resp_q.delete();
    exp_q.delete();
    model_ot = 1'b0;
    avg_fill = 1'b1;
    repeat (3) @(negedge clk);
    clear_counts();
    push_resp(1, 20, 0, 16'h1900);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    tests_run++;
    if (n_start != 1 || n_valid != 0) begin
      tests_failed++;
      $display("FAIL reset_release: got starts=%0d valids=%0d, want 1 0", n_start, n_valid);
    end
    repeat (30) @(negedge clk);
    enable = 1'b0;
    repeat (30) @(negedge clk);
    tests_run++;
    if (n_start != 1 || n_valid != 1) begin
      tests_failed++;
      $display("FAIL reset_resume: got starts=%0d valids=%0d, want 1 1", n_start, n_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_timeout();
`ifdef TCU_SCHED_AVG_EN
    test_average();
`else
    test_over_temp();
`endif
    test_reset_mid();
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending samples, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
